// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   BUS_64         default data/address width of the data-memory bus
//   size_e         access size encoded in funct3[1:0]
//   F3_ZEXT_BIT    funct3 bit that selects zero-extension (LBU/LHU/LWU)
//   state_e        control states of mem_stage
//   size_mask()    byte-enable pattern of an access at byte offset 0
// ----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int BUS_64      = 64;
   localparam int F3_ZEXT_BIT = 2;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [7:0] size_mask(input size_e sz);
      case (sz)
         SZ_BYTE:  return 8'h01;
         SZ_HALF:  return 8'h03;
         SZ_WORD:  return 8'h0F;
         default:  return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_fmt.sv
// ----------------------------------------------------------------------------
// mem_fmt
// Combinational data formatting for the memory stage.
//   funct3    in   access size / sign selection
//   off       in   byte offset inside the 8-byte bus word
//   st_data   in   store data (rs2), right-aligned
//   st_mask   out  byte enables (size mask shifted to the offset, 8 bits kept)
//   st_wdata  out  store data shifted onto its byte lanes
//   ld_rdata  in   raw bus read data
//   ld_value  out  loaded value, shifted down, truncated and extended
// Lanes shifted past byte 7 are dropped.
// ----------------------------------------------------------------------------
module mem_fmt
   import mem_stage_pkg::*;
#(
   parameter int XLEN = BUS_64
) (
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] st_data,
   output logic [7:0]      st_mask,
   output logic [XLEN-1:0] st_wdata,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_value
);

   logic [5:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic            sext;
   size_e           sz;

   assign shamt   = {off, 3'b000};
   assign sz      = size_e'(funct3[1:0]);
   assign sext    = ~funct3[F3_ZEXT_BIT];

   assign st_mask  = size_mask(sz) << off;
   assign st_wdata = st_data << shamt;
   assign shifted  = ld_rdata >> shamt;

   // NOTE: give ld_value a value on every path through always_comb, otherwise a latch is inferred.
   always_comb begin
      ld_value = shifted;
      case (sz)
         SZ_BYTE: ld_value = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
         SZ_HALF: ld_value = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
         SZ_WORD: ld_value = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
         default: ld_value = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between execute and wb_stage. Accepts one
// instruction per req/ack handshake, performs at most one data-memory access,
// and presents rd / rd_wen / rd_wdata to wb_stage with a req/ack pair.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mem_executed_req_i/ack_o  upstream handshake (ack_o high only in IDLE)
//   mem_memoryed_req_o/ack_i  downstream handshake to wb_stage
//   mem_rd_i/rd_wen_i/rd_wdata_i  destination register and ALU result
//   mem_ren_i/wen_i/funct3_i  load/store flags and access size/sign
//   mem_addr_i/wdata_i        effective address and store data
//   mem_rd_o/rd_wen_o/rd_wdata_o  write-back result
//   dmem_*                    data-memory bus (req held until single-cycle ack)
//
// Optional build macro MEM_MISALIGN_CHK_EN: adds mem_misalign_o; a memory op
// whose address is not aligned to its size bypasses the bus, suppresses the
// register write and flags mem_misalign_o while the result is presented.
// ----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN = BUS_64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_executed_req_i,
   output logic            mem_executed_ack_o,
   output logic            mem_memoryed_req_o,
   input  logic            mem_memoryed_ack_i,
   input  logic [4:0]      mem_rd_i,
   input  logic            mem_rd_wen_i,
   input  logic [XLEN-1:0] mem_rd_wdata_i,
   input  logic            mem_ren_i,
   input  logic            mem_wen_i,
   input  logic [2:0]      mem_funct3_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   output logic [4:0]      mem_rd_o,
   output logic            mem_rd_wen_o,
   output logic [XLEN-1:0] mem_rd_wdata_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [7:0]      dmem_wmask_o,
   input  logic [XLEN-1:0] dmem_rdata_i,
   input  logic            dmem_ack_i
`ifdef MEM_MISALIGN_CHK_EN
   ,
   output logic            mem_misalign_o
`endif
);

   state_e          state;
   logic            hs;
   logic            mem_op;
   logic [2:0]      funct3_q;
   logic [2:0]      off_q;
   logic            load_q;
   logic [2:0]      fmt_funct3;
   logic [2:0]      fmt_off;
   logic [7:0]      st_mask;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_value;

   assign mem_executed_ack_o = (state == IDLE);
   assign hs                 = mem_executed_req_i & mem_executed_ack_o;
   assign mem_op             = mem_ren_i | mem_wen_i;

   // Store formatting is needed at accept time (live inputs); load extraction
   // happens in BUS from the latched size and offset.
   assign fmt_funct3 = (state == IDLE) ? mem_funct3_i    : funct3_q;
   assign fmt_off    = (state == IDLE) ? mem_addr_i[2:0] : off_q;

   mem_fmt #(.XLEN(XLEN)) u_fmt (
      .funct3   (fmt_funct3),
      .off      (fmt_off),
      .st_data  (mem_wdata_i),
      .st_mask  (st_mask),
      .st_wdata (st_wdata),
      .ld_rdata (dmem_rdata_i),
      .ld_value (ld_value)
   );

`ifdef MEM_MISALIGN_CHK_EN
   logic misaligned;

   always_comb begin
      misaligned = 1'b0;
      case (size_e'(mem_funct3_i[1:0]))
         SZ_HALF:  misaligned = mem_addr_i[0];
         SZ_WORD:  misaligned = |mem_addr_i[1:0];
         SZ_DWORD: misaligned = |mem_addr_i[2:0];
         default:  misaligned = 1'b0;
      endcase
   end
`endif

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         funct3_q           <= '0;
         off_q              <= '0;
         load_q             <= 1'b0;
         mem_memoryed_req_o <= 1'b0;
         mem_rd_o           <= '0;
         mem_rd_wen_o       <= 1'b0;
         mem_rd_wdata_o     <= '0;
         dmem_req_o         <= 1'b0;
         dmem_we_o          <= 1'b0;
         dmem_addr_o        <= '0;
         dmem_wdata_o       <= '0;
         dmem_wmask_o       <= '0;
`ifdef MEM_MISALIGN_CHK_EN
         mem_misalign_o     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  mem_rd_o       <= mem_rd_i;
                  mem_rd_wdata_o <= mem_rd_wdata_i;
                  funct3_q       <= mem_funct3_i;
                  off_q          <= mem_addr_i[2:0];
                  // A store wins when both ren and wen are set.
                  load_q         <= mem_ren_i & ~mem_wen_i;
                  if (!mem_op) begin
                     mem_rd_wen_o       <= mem_rd_wen_i;
                     mem_memoryed_req_o <= 1'b1;
                     state              <= DONE;
                  end
`ifdef MEM_MISALIGN_CHK_EN
                  else if (misaligned) begin
                     mem_rd_wen_o       <= 1'b0;
                     mem_memoryed_req_o <= 1'b1;
                     mem_misalign_o     <= 1'b1;
                     state              <= DONE;
                  end
`endif
                  else begin
                     mem_rd_wen_o <= mem_rd_wen_i & ~mem_wen_i;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= mem_wen_i;
                     dmem_addr_o  <= {mem_addr_i[XLEN-1:3], 3'b000};
                     dmem_wdata_o <= st_wdata;
                     dmem_wmask_o <= st_mask;
                     state        <= BUS;
                  end
               end
            end
            BUS: begin
               if (dmem_ack_i) begin
                  dmem_req_o         <= 1'b0;
                  mem_memoryed_req_o <= 1'b1;
                  if (load_q) begin
                     mem_rd_wdata_o <= ld_value;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               if (mem_memoryed_ack_i) begin
                  mem_memoryed_req_o <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
                  mem_misalign_o     <= 1'b0;
`endif
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: a directed vector table, hand-written
// sequences for downstream stall, reset during a bus access and stray bus
// acks, then randomized transactions checked against a reference model
// derived from the byte-lane arithmetic of the stage.
// ----------------------------------------------------------------------------
module tb_mem_stage;

   localparam int XLEN = 64;
   localparam int NV   = 11;
   localparam int NRND = 200;

   logic            clk = 1'b0;
   logic            rst;
   logic            mem_executed_req_i;
   logic            mem_executed_ack_o;
   logic            mem_memoryed_req_o;
   logic            mem_memoryed_ack_i;
   logic [4:0]      mem_rd_i;
   logic            mem_rd_wen_i;
   logic [XLEN-1:0] mem_rd_wdata_i;
   logic            mem_ren_i;
   logic            mem_wen_i;
   logic [2:0]      mem_funct3_i;
   logic [XLEN-1:0] mem_addr_i;
   logic [XLEN-1:0] mem_wdata_i;
   logic [4:0]      mem_rd_o;
   logic            mem_rd_wen_o;
   logic [XLEN-1:0] mem_rd_wdata_o;
   logic            dmem_req_o;
   logic            dmem_we_o;
   logic [XLEN-1:0] dmem_addr_o;
   logic [XLEN-1:0] dmem_wdata_o;
   logic [7:0]      dmem_wmask_o;
   logic [XLEN-1:0] dmem_rdata_i;
   logic            dmem_ack_i;
`ifdef MEM_MISALIGN_CHK_EN
   logic            mem_misalign_o;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   mem_stage #(.XLEN(XLEN)) dut (
      .clk                (clk),
      .rst                (rst),
      .mem_executed_req_i (mem_executed_req_i),
      .mem_executed_ack_o (mem_executed_ack_o),
      .mem_memoryed_req_o (mem_memoryed_req_o),
      .mem_memoryed_ack_i (mem_memoryed_ack_i),
      .mem_rd_i           (mem_rd_i),
      .mem_rd_wen_i       (mem_rd_wen_i),
      .mem_rd_wdata_i     (mem_rd_wdata_i),
      .mem_ren_i          (mem_ren_i),
      .mem_wen_i          (mem_wen_i),
      .mem_funct3_i       (mem_funct3_i),
      .mem_addr_i         (mem_addr_i),
      .mem_wdata_i        (mem_wdata_i),
      .mem_rd_o           (mem_rd_o),
      .mem_rd_wen_o       (mem_rd_wen_o),
      .mem_rd_wdata_o     (mem_rd_wdata_o),
      .dmem_req_o         (dmem_req_o),
      .dmem_we_o          (dmem_we_o),
      .dmem_addr_o        (dmem_addr_o),
      .dmem_wdata_o       (dmem_wdata_o),
      .dmem_wmask_o       (dmem_wmask_o),
      .dmem_rdata_i       (dmem_rdata_i),
      .dmem_ack_i         (dmem_ack_i)
`ifdef MEM_MISALIGN_CHK_EN
      ,
      .mem_misalign_o     (mem_misalign_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string           name;
      logic [4:0]      rd;
      logic            rd_wen;
      logic [XLEN-1:0] alu;
      logic            ren;
      logic            wen;
      logic [2:0]      f3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] rdata;
      int              delay;
      logic            e_bus;
      logic            e_we;
      logic [XLEN-1:0] e_daddr;
      logic [7:0]      e_mask;
      logic [XLEN-1:0] e_dwdata;
      logic            e_rd_wen;
      logic            e_chk_wdata;
      logic [XLEN-1:0] e_rd_wdata;
      logic            e_mis;
   } vec_t;

   vec_t vecs[NV];

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input string name, input logic [4:0] rd, input logic rd_wen, input logic [XLEN-1:0] alu,
      input logic ren, input logic wen, input logic [2:0] f3, input logic [XLEN-1:0] addr,
      input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata, input int delay,
      input logic e_bus, input logic e_we, input logic [XLEN-1:0] e_daddr, input logic [7:0] e_mask,
      input logic [XLEN-1:0] e_dwdata, input logic e_rd_wen, input logic e_chk_wdata,
      input logic [XLEN-1:0] e_rd_wdata, input logic e_mis);
      vec_t v;
      v.name = name;       v.rd = rd;           v.rd_wen = rd_wen;     v.alu = alu;
      v.ren = ren;         v.wen = wen;         v.f3 = f3;             v.addr = addr;
      v.wdata = wdata;     v.rdata = rdata;     v.delay = delay;
      v.e_bus = e_bus;     v.e_we = e_we;       v.e_daddr = e_daddr;   v.e_mask = e_mask;
      v.e_dwdata = e_dwdata; v.e_rd_wen = e_rd_wen; v.e_chk_wdata = e_chk_wdata;
      v.e_rd_wdata = e_rd_wdata; v.e_mis = e_mis;
      return v;
   endfunction

   // Reference load: shift the addressed bytes down, keep 2^size bytes, extend.
   function automatic logic [XLEN-1:0] model_load(input logic [XLEN-1:0] rdata, input logic [2:0] f3,
                                                  input int off);
      logic [XLEN-1:0] v;
      logic [XLEN-1:0] m;
      int              nbits;
      nbits = 8 * (1 << f3[1:0]);
      v     = rdata >> (8 * off);
      if (nbits < 64) begin
         m = (64'd1 << nbits) - 64'd1;
         v = v & m;
         if (!f3[2] && v[nbits-1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic vec_t model(input logic [4:0] rd, input logic rd_wen, input logic [XLEN-1:0] alu,
                                  input logic ren, input logic wen, input logic [2:0] f3,
                                  input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                                  input logic [XLEN-1:0] rdata, input int delay);
      vec_t v;
      int   nbytes;
      int   off;
      int   m;
      logic mis;
      nbytes = 1 << f3[1:0];
      off    = int'(addr[2:0]);
      mis    = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      mis = (ren || wen) && ((off % nbytes) != 0);
`endif
      m = ((1 << nbytes) - 1) << off;
      v = mk("rnd", rd, rd_wen, alu, ren, wen, f3, addr, wdata, rdata, delay,
             1'b0, 1'b0, '0, 8'h00, '0, 1'b0, 1'b0, '0, mis);
      if (!(ren || wen)) begin
         v.e_rd_wen = rd_wen;  v.e_chk_wdata = 1'b1;  v.e_rd_wdata = alu;
      end else if (!mis) begin
         v.e_bus    = 1'b1;
         v.e_we     = wen;
         v.e_daddr  = addr - 64'(off);
         v.e_mask   = m[7:0];
         v.e_dwdata = wdata << (8 * off);
         v.e_rd_wen = wen ? 1'b0 : rd_wen;
         if (!wen) begin
            v.e_chk_wdata = 1'b1;
            v.e_rd_wdata  = model_load(rdata, f3, off);
         end
      end
      return v;
   endfunction

   task automatic scramble_inputs();
      mem_rd_i       = 5'($urandom);
      mem_rd_wen_i   = 1'($urandom);
      mem_rd_wdata_i = {$urandom, $urandom};
      mem_ren_i      = 1'($urandom);
      mem_wen_i      = 1'($urandom);
      mem_funct3_i   = 3'($urandom);
      mem_addr_i     = {$urandom, $urandom};
      mem_wdata_i    = {$urandom, $urandom};
   endtask

   // Drive one instruction through the stage, checking it at each phase.
   task automatic run_vec(input vec_t v);
      for (int i = 0; i < 20 && !mem_executed_ack_o; i++) @(negedge clk);
      check({v.name, "/ready"}, mem_executed_ack_o, 1);
      mem_executed_req_i = 1'b1;
      mem_rd_i = v.rd;     mem_rd_wen_i = v.rd_wen;   mem_rd_wdata_i = v.alu;
      mem_ren_i = v.ren;   mem_wen_i = v.wen;         mem_funct3_i = v.f3;
      mem_addr_i = v.addr; mem_wdata_i = v.wdata;
      @(negedge clk);
      mem_executed_req_i = 1'b0;
      scramble_inputs();
      if (v.e_bus) begin
         check({v.name, "/dmem_req"}, dmem_req_o, 1);
         check({v.name, "/dmem_we"}, dmem_we_o, v.e_we);
         check({v.name, "/dmem_addr"}, dmem_addr_o, v.e_daddr);
         check({v.name, "/dmem_wmask"}, dmem_wmask_o, v.e_mask);
         if (v.e_we) check({v.name, "/dmem_wdata"}, dmem_wdata_o, v.e_dwdata);
         check({v.name, "/early_req"}, mem_memoryed_req_o, 0);
         for (int i = 0; i < v.delay; i++) begin
            dmem_rdata_i = {$urandom, $urandom};
            @(negedge clk);
         end
         check({v.name, "/dmem_hold"}, dmem_req_o, 1);
         check({v.name, "/dmem_addr_hold"}, dmem_addr_o, v.e_daddr);
         dmem_ack_i   = 1'b1;
         dmem_rdata_i = v.rdata;
         @(negedge clk);
         dmem_ack_i   = 1'b0;
         dmem_rdata_i = {$urandom, $urandom};
         check({v.name, "/dmem_drop"}, dmem_req_o, 0);
      end else begin
         check({v.name, "/no_dmem"}, dmem_req_o, 0);
      end
      check({v.name, "/req"}, mem_memoryed_req_o, 1);
      check({v.name, "/rd"}, mem_rd_o, v.rd);
      check({v.name, "/rd_wen"}, mem_rd_wen_o, v.e_rd_wen);
      if (v.e_chk_wdata) check({v.name, "/rd_wdata"}, mem_rd_wdata_o, v.e_rd_wdata);
`ifdef MEM_MISALIGN_CHK_EN
      check({v.name, "/misalign"}, mem_misalign_o, v.e_mis);
`endif
      mem_memoryed_ack_i = 1'b1;
      @(negedge clk);
      mem_memoryed_ack_i = 1'b0;
      check({v.name, "/release"}, mem_memoryed_req_o, 0);
      check({v.name, "/idle"}, mem_executed_ack_o, 1);
   endtask

   initial begin
      vecs[0] = mk("alu", 5'd5, 1, 64'h1234, 0, 0, 3'd0, 64'h0, 64'hDEAD, 64'h0, 0,
                   0, 0, 64'h0, 8'h00, 64'h0, 1, 1, 64'h1234, 0);
      vecs[1] = mk("lb", 5'd7, 1, 64'h0, 1, 0, 3'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3,
                   1, 0, 64'h1000, 8'h08, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
      vecs[2] = mk("lbu", 5'd8, 1, 64'h0, 1, 0, 3'd4, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3,
                   1, 0, 64'h1000, 8'h08, 64'h0, 1, 1, 64'h80, 0);
      vecs[3] = mk("sh", 5'd9, 1, 64'h55, 0, 1, 3'd1, 64'h2006, 64'hABCD, 64'h0, 1,
                   1, 1, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 0, 0, 64'h0, 0);
      vecs[4] = mk("lw", 5'd10, 1, 64'h0, 1, 0, 3'd2, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 0,
                   1, 0, 64'h3000, 8'hF0, 64'h0, 1, 1, 64'hFFFF_FFFF_8765_4321, 0);
      vecs[5] = mk("ld", 5'd11, 1, 64'h0, 1, 0, 3'd3, 64'h8, 64'h0, 64'hDEAD_BEEF_0123_4567, 2,
                   1, 0, 64'h8, 8'hFF, 64'h0, 1, 1, 64'hDEAD_BEEF_0123_4567, 0);
      vecs[6] = mk("ren_wen_sd", 5'd12, 1, 64'h77, 1, 1, 3'd3, 64'h10, 64'h1122_3344_5566_7788, 64'hFFFF, 1,
                   1, 1, 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 64'h0, 0);
      vecs[7] = mk("lhu", 5'd13, 1, 64'h0, 1, 0, 3'd5, 64'h4002, 64'h0, 64'h0000_0000_F00D_0000, 1,
                   1, 0, 64'h4000, 8'h0C, 64'h0, 1, 1, 64'hF00D, 0);
      vecs[8] = mk("lwu", 5'd14, 1, 64'h0, 1, 0, 3'd6, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 0,
                   1, 0, 64'h3000, 8'hF0, 64'h0, 1, 1, 64'h0000_0000_8765_4321, 0);
      vecs[9] = mk("lh_nowen", 5'd3, 0, 64'h0, 1, 0, 3'd1, 64'h6000, 64'h0, 64'h8001, 0,
                   1, 0, 64'h6000, 8'h03, 64'h0, 0, 1, 64'hFFFF_FFFF_FFFF_8001, 0);
`ifdef MEM_MISALIGN_CHK_EN
      vecs[10] = mk("lw_misalign", 5'd15, 1, 64'h99, 1, 0, 3'd2, 64'h3002, 64'h0, 64'h0, 0,
                    0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 64'h0, 1);
`else
      vecs[10] = mk("sw_cross", 5'd15, 1, 64'h0, 0, 1, 3'd2, 64'h5006, 64'hAABB_CCDD, 64'h0, 0,
                    1, 1, 64'h5000, 8'hC0, 64'hCCDD_0000_0000_0000, 0, 0, 64'h0, 0);
`endif

      rst = 1'b1;
      mem_executed_req_i = 1'b0;
      mem_memoryed_ack_i = 1'b0;
      dmem_ack_i         = 1'b0;
      dmem_rdata_i       = '0;
      scramble_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset/exec_ack", mem_executed_ack_o, 1);
      check("reset/mem_req", mem_memoryed_req_o, 0);
      check("reset/dmem_req", dmem_req_o, 0);
      check("reset/rd_wen", mem_rd_wen_o, 0);
      check("reset/rd_wdata", mem_rd_wdata_o, 0);
      check("reset/dmem_addr", dmem_addr_o, 0);
      check("reset/dmem_wmask", dmem_wmask_o, 0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Downstream stall with upstream request held high.
      mem_executed_req_i = 1'b1;
      mem_rd_i = 5'd21; mem_rd_wen_i = 1'b1; mem_rd_wdata_i = 64'hCAFE;
      mem_ren_i = 1'b0; mem_wen_i = 1'b0;
      @(negedge clk);
      check("stall/req", mem_memoryed_req_o, 1);
      mem_rd_i = 5'd22; mem_rd_wdata_i = 64'hBEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall/no_accept", mem_executed_ack_o, 0);
         check("stall/req_hold", mem_memoryed_req_o, 1);
         check("stall/rd_hold", mem_rd_o, 21);
         check("stall/wdata_hold", mem_rd_wdata_o, 64'hCAFE);
      end
      mem_memoryed_ack_i = 1'b1;
      @(negedge clk);
      mem_memoryed_ack_i = 1'b0;
      check("stall/release", mem_memoryed_req_o, 0);
      check("stall/reaccept_ready", mem_executed_ack_o, 1);
      @(negedge clk);
      mem_executed_req_i = 1'b0;
      check("stall/second_req", mem_memoryed_req_o, 1);
      check("stall/second_rd", mem_rd_o, 22);
      check("stall/second_wdata", mem_rd_wdata_o, 64'hBEEF);
      mem_memoryed_ack_i = 1'b1;
      @(negedge clk);
      mem_memoryed_ack_i = 1'b0;

      // Reset while waiting on the bus abandons the access.
      mem_executed_req_i = 1'b1;
      mem_ren_i = 1'b1; mem_wen_i = 1'b0; mem_funct3_i = 3'd3; mem_addr_i = 64'h7000;
      @(negedge clk);
      mem_executed_req_i = 1'b0;
      check("rst_bus/dmem_req", dmem_req_o, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_bus/dmem_drop", dmem_req_o, 0);
      check("rst_bus/mem_req", mem_memoryed_req_o, 0);
      check("rst_bus/exec_ack", mem_executed_ack_o, 1);
      rst = 1'b0;
      @(negedge clk);

      // A stray bus ack in IDLE is ignored.
      dmem_ack_i = 1'b1;
      @(negedge clk);
      dmem_ack_i = 1'b0;
      check("stray_ack/mem_req", mem_memoryed_req_o, 0);
      check("stray_ack/dmem_req", dmem_req_o, 0);
      check("stray_ack/exec_ack", mem_executed_ack_o, 1);

      for (int n = 0; n < NRND; n++) begin
         logic [1:0] kind;
         kind = 2'($urandom);
         run_vec(model(5'($urandom), 1'($urandom), {$urandom, $urandom},
                       kind[0], kind[1], 3'($urandom), {$urandom, $urandom},
                       {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage. It sits between the execute stage and wb_stage.
- Accepts one executed instruction per req/ack handshake.
- Performs at most one load or store on the data-memory bus.
- Forms the final rd write-back data.
- Presents the result to wb_stage through the memoryed req/ack pair.
Non-memory instructions pass the ALU result straight through.

Parameters:
XLEN, 64, data and address width.

Ports:
clk  in  1  clock
rst  in  1  reset
mem_executed_req_i  in  1  upstream has a valid instruction
mem_executed_ack_o  out  1  stage accepts the instruction
mem_memoryed_req_o  out  1  result valid to wb_stage
mem_memoryed_ack_i  in  1  wb_stage accepted the result
mem_rd_i  in  5  destination register
mem_rd_wen_i  in  1  rd write enable
mem_rd_wdata_i  in  XLEN  ALU result
mem_ren_i  in  1  load instruction
mem_wen_i  in  1  store instruction
mem_funct3_i  in  3  access size/sign
mem_addr_i  in  XLEN  effective address
mem_wdata_i  in  XLEN  store data (rs2)
mem_rd_o  out  5  to wb_stage
mem_rd_wen_o  out  1  to wb_stage
mem_rd_wdata_o  out  XLEN  to wb_stage
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  XLEN  8-byte aligned address (addr & ~7)
dmem_wdata_o  out  XLEN  lane-shifted store data
dmem_wmask_o  out  8  byte enables
dmem_rdata_i  in  XLEN  read data, valid with ack
dmem_ack_i  in  1  bus completes the transfer (single-cycle pulse)

Behaviour:
Reset and state machine
- Reset (rst, synchronous, active-high; clock clk): state IDLE; all outputs and internal registers 0.
- States: IDLE, BUS, DONE.
- mem_executed_ack_o = (state==IDLE), combinational.
- Handshake hs = req_i & ack_o. On hs, latch all *_i inputs.

Transitions
- IDLE, hs, no memory op: go to DONE.
  - Outputs: rd_o = rd_i, rd_wen_o = rd_wen_i, rd_wdata_o = rd_wdata_i.
  - mem_memoryed_req_o = 1 next cycle (latency 1).
- IDLE, hs, memory op: go to BUS.
  - dmem_req_o = 1 next cycle. Drive address, we, data and mask from the latched values.
  - If both ren and wen are set, the store takes precedence (we=1, rd_wen_o=0).
- BUS: hold dmem_req_o and all dmem outputs stable until dmem_ack_i.
  - On dmem_ack_i: dmem_req_o = 0 next cycle, go to DONE, set mem_memoryed_req_o = 1.
  - Load: rd_wdata_o = extended load value. Store: rd_wen_o = 0.
- DONE: hold outputs stable until mem_memoryed_ack_i. Then req_o = 0 and go to IDLE.
  - A new instruction can be accepted one cycle after the ack.
  - No new request is accepted while in DONE.

Data formatting
- Byte offset off = addr[2:0].
- Size: funct3[1:0] = 0 byte, 1 half, 2 word, 3 dword. funct3[2] = 1 means zero-extend (LBU/LHU/LWU).
- Store: wmask = size_mask << off, with size_mask 0x01/0x03/0x0F/0xFF. wdata = mem_wdata << (off*8).
- Load: value = rdata >> (off*8), truncated to size, then sign- or zero-extended to 64 bits.
- Accesses that cross 8 bytes are not supported when the feature is off. The mask is truncated to 8 bits, so excess bytes are dropped.

Boundary conditions
- rst during BUS: dmem_req_o drops the next cycle and the transaction is abandoned; the bus must tolerate this.
- dmem_ack_i outside BUS is ignored.
- mem_executed_req_i held high across cycles causes no duplicate accept: accepting requires IDLE.

Optional Feature:
MEM_MISALIGN_CHK_EN
- Defined:
  - Extra output mem_misalign_o (1 bit).
  - On hs, a memory op with addr not aligned to its size skips BUS and goes directly to DONE.
  - In that case rd_wen_o = 0, no bus request is issued, and mem_misalign_o = 1 for as long as the stage is in DONE.
- Undefined: no port; truncation behaviour as described above.

Decomposition:
- Shared defines: BUS_64, funct3 size/sign encodings, state encodings.
- One sub-module, mem_fmt: combinational store lane/mask generation and load extraction/extension. Keeps the FSM module small.

Test Plan:
- ALU op, rd=5, wen=1, wdata=0x1234, ack_i held 1 -> req_o high 1 cycle after hs with rd_o=5, wdata_o=0x1234; no dmem_req_o.
- LB addr=0x1003, rdata=0x00000000_80000000, ack after 3 cycles -> dmem_addr_o=0x1000; wdata_o=0xFFFF_FFFF_FFFF_FF80; LBU of the same access gives 0x80.
- SH addr=0x2006, wdata=0xABCD -> dmem_we_o=1, wmask=0xC0, dmem_wdata_o=0xABCD_0000_0000_0000, rd_wen_o=0.
- Downstream ack_i held 0 for 5 cycles in DONE, upstream req_i=1 -> ack_o stays 0; outputs stable; accept resumes 1 cycle after ack_i.
- rst asserted while in BUS -> next cycle dmem_req_o=0, req_o=0, state IDLE, ack_o=1.
- (MEM_MISALIGN_CHK_EN) LW addr=0x3002 -> no dmem_req_o; mem_misalign_o=1; rd_wen_o=0.
